// File: rtl/pkg_elevador.sv
// Shared types and constants for the four-floor elevator controller.
package pkg_elevador;

  localparam int         NUM_ANDARES  = 4;
  localparam logic [1:0] CAP_EXCEDIDA = 2'b11;

  typedef enum logic [1:0] {
    PARADO,
    SUBINDO,
    DESCENDO,
    PORTA_ABERTA
  } estado_t;

endpackage

// File: rtl/temporizador_elevador.sv
// 8-bit loadable down-counter; saturates at zero, where the done flag is raised.
module temporizador_elevador (
  input  logic       clk,
  input  logic       reset,
  input  logic       carga,
  input  logic [7:0] valor,
  input  logic       habilita,
  output logic       fim
);

  logic [7:0] cont_q, cont_d;

  always_comb begin
    cont_d = cont_q;
    if (carga) begin
      cont_d = valor;
    end else if (habilita && (cont_q != 8'd0)) begin
      cont_d = cont_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cont_q <= 8'd0;
    end else begin
      cont_q <= cont_d;
    end
  end

  assign fim = (cont_q == 8'd0);

endmodule

// File: rtl/controle_elevador.sv
// Four-floor elevator controller: call latching, direction choice, travel and door timing.
module controle_elevador
  import pkg_elevador::*;
#(
  parameter int unsigned CICLOS_ANDAR = 8,
  parameter int unsigned CICLOS_PORTA = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ANDARES-1:0] chamada,
  input  logic [1:0]             capacidade_atual,
  output logic [1:0]             andar_atual,
  output logic                   motor_sobe,
  output logic                   motor_desce,
  output logic                   porta_aberta,
  output logic [NUM_ANDARES-1:0] chamadas_pendentes,
  output logic                   excesso
);

  // Timer is loaded with N-1 so the state lasts exactly N cycles, ending on the done cycle.
  localparam logic [7:0] CARGA_ANDAR = 8'(CICLOS_ANDAR - 1);
  localparam logic [7:0] CARGA_PORTA = 8'(CICLOS_PORTA - 1);

  estado_t                estado_q, estado_d;
  logic [1:0]             andar_q, andar_d;
  logic [NUM_ANDARES-1:0] pend_q, pend_d;
  logic                   dir_sobe_q, dir_sobe_d;

  logic [NUM_ANDARES-1:0] efetivas, acima, abaixo;
  logic                   ha_acima, ha_abaixo;
  logic                   tmr_carga, tmr_habilita, tmr_fim;
  logic [7:0]             tmr_valor;

  for (genvar gi = 0; gi < NUM_ANDARES; gi++) begin : g_mascara
    assign acima[gi]  = (2'(gi) > andar_q);
    assign abaixo[gi] = (2'(gi) < andar_q);
  end

  assign excesso   = (capacidade_atual == CAP_EXCEDIDA);
  assign efetivas  = pend_q | chamada;
  assign ha_acima  = |(efetivas & acima);
  assign ha_abaixo = |(efetivas & abaixo);

  always_comb begin
    estado_d     = estado_q;
    andar_d      = andar_q;
    dir_sobe_d   = dir_sobe_q;
    pend_d       = pend_q | chamada;
    tmr_carga    = 1'b0;
    tmr_valor    = 8'd0;
    tmr_habilita = 1'b0;

    case (estado_q)
      PARADO: begin
        if (efetivas[andar_q]) begin
          estado_d        = PORTA_ABERTA;
          pend_d[andar_q] = 1'b0;
          tmr_carga       = 1'b1;
          tmr_valor       = CARGA_PORTA;
        end else if (ha_acima && (andar_q != 2'd3) && (dir_sobe_q || !ha_abaixo)) begin
          estado_d   = SUBINDO;
          dir_sobe_d = 1'b1;
          tmr_carga  = 1'b1;
          tmr_valor  = CARGA_ANDAR;
        end else if (ha_abaixo && (andar_q != 2'd0)) begin
          estado_d   = DESCENDO;
          dir_sobe_d = 1'b0;
          tmr_carga  = 1'b1;
          tmr_valor  = CARGA_ANDAR;
        end
      end

      SUBINDO: begin
        tmr_habilita = 1'b1;
        if (tmr_fim) begin
          andar_d  = andar_q + 2'd1;
          estado_d = PARADO;
        end
      end

      DESCENDO: begin
        tmr_habilita = 1'b1;
        if (tmr_fim) begin
          andar_d  = andar_q - 2'd1;
          estado_d = PARADO;
        end
      end

      PORTA_ABERTA: begin
        // A call for this floor is absorbed by holding the door, never latched.
        pend_d[andar_q] = 1'b0;
        tmr_habilita    = 1'b1;
        // Reloading every overloaded cycle makes the full door time restart when load drops.
        if (chamada[andar_q] || excesso) begin
          tmr_carga = 1'b1;
          tmr_valor = CARGA_PORTA;
        end else if (tmr_fim) begin
          estado_d = PARADO;
        end
      end

      default: estado_d = PARADO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= PARADO;
      andar_q    <= 2'd0;
      pend_q     <= '0;
      dir_sobe_q <= 1'b1;
    end else begin
      estado_q   <= estado_d;
      andar_q    <= andar_d;
      pend_q     <= pend_d;
      dir_sobe_q <= dir_sobe_d;
    end
  end

  temporizador_elevador u_temporizador (
    .clk      (clk),
    .reset    (reset),
    .carga    (tmr_carga),
    .valor    (tmr_valor),
    .habilita (tmr_habilita),
    .fim      (tmr_fim)
  );

  assign andar_atual        = andar_q;
  assign motor_sobe         = (estado_q == SUBINDO);
  assign motor_desce        = (estado_q == DESCENDO);
  assign porta_aberta       = (estado_q == PORTA_ABERTA);
  assign chamadas_pendentes = pend_q;

endmodule

// File: tb/tb_controle_elevador.sv
// Directed self-checking bench for controle_elevador with hand-derived cycle expectations.
module tb_controle_elevador;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] chamada;
  logic [1:0] capacidade_atual;
  logic [1:0] andar_atual;
  logic       motor_sobe;
  logic       motor_desce;
  logic       porta_aberta;
  logic [3:0] chamadas_pendentes;
  logic       excesso;

  logic [4:0] saida;
  int         n_erros  = 0;
  int         n_checks = 0;

  always #5 clk = ~clk;

  controle_elevador #(
    .CICLOS_ANDAR (8),
    .CICLOS_PORTA (4)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .chamada            (chamada),
    .capacidade_atual   (capacidade_atual),
    .andar_atual        (andar_atual),
    .motor_sobe         (motor_sobe),
    .motor_desce        (motor_desce),
    .porta_aberta       (porta_aberta),
    .chamadas_pendentes (chamadas_pendentes),
    .excesso            (excesso)
  );

  // {floor, up, down, door}
  assign saida = {andar_atual, motor_sobe, motor_desce, porta_aberta};

  task automatic checar(input string tag, input logic [7:0] obs, input logic [7:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_erros++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, esp);
    end
  endtask

  task automatic passo();
    @(posedge clk);
    #1;
  endtask

  // One floor of travel (8 motor cycles) followed by the one-cycle stop at the destination.
  task automatic trecho(input string tag, input logic sobe, input logic [1:0] origem,
                        input logic [3:0] meio);
    logic [1:0] destino;
    destino = sobe ? origem + 2'd1 : origem - 2'd1;
    for (int i = 0; i < 8; i++) begin
      chamada = (i == 1) ? meio : 4'b0000;
      checar(tag, {3'b0, saida}, {3'b0, origem, sobe, ~sobe, 1'b0});
      passo();
    end
    chamada = 4'b0000;
    checar({tag, "_parada"}, {3'b0, saida}, {3'b0, destino, 3'b000});
    passo();
  endtask

  // n door-open cycles, then the closed (PARADO) cycle.
  task automatic porta_ciclos(input string tag, input logic [1:0] andar, input int n);
    for (int i = 0; i < n; i++) begin
      checar(tag, {3'b0, saida}, {3'b0, andar, 3'b001});
      passo();
    end
    checar({tag, "_fechada"}, {3'b0, saida}, {3'b0, andar, 3'b000});
    passo();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset            = 1'b1;
    chamada          = 4'b0000;
    capacidade_atual = 2'b11;
    passo();
    passo();
    checar("rst_saida", {3'b0, saida}, 8'h00);
    checar("rst_pend", {4'b0, chamadas_pendentes}, 8'h00);
    checar("rst_excesso1", {7'b0, excesso}, 8'h01);
    capacidade_atual = 2'b00;
    #1;
    checar("rst_excesso0", {7'b0, excesso}, 8'h00);
    chamada = 4'b1111;
    passo();
    checar("rst_segura", {3'b0, saida}, 8'h00);
    checar("rst_segura_pend", {4'b0, chamadas_pendentes}, 8'h00);
    chamada = 4'b0000;
    reset   = 1'b0;
    $display("transaction: reset state");

    // Call at the current floor: door for 4 cycles, then a re-call reloads the timer.
    chamada = 4'b0001;
    checar("a_parado", {3'b0, saida}, 8'h00);
    passo();
    chamada = 4'b0000;
    porta_ciclos("a_porta", 2'd0, 4);
    checar("a_pend", {4'b0, chamadas_pendentes}, 8'h00);
    chamada = 4'b0001;
    passo();
    chamada = 4'b0000;
    checar("a_rec_c1", {3'b0, saida}, 8'h01);
    passo();
    checar("a_rec_c2", {3'b0, saida}, 8'h01);
    passo();
    chamada = 4'b0001;
    checar("a_rec_c3", {3'b0, saida}, 8'h01);
    passo();
    chamada = 4'b0000;
    checar("a_rec_pend", {4'b0, chamadas_pendentes}, 8'h00);
    porta_ciclos("a_recarga", 2'd0, 4);
    $display("transaction: door at floor 0 and reload");

    // Call to floor 3: three legs up with stops at 1 and 2.
    chamada = 4'b1000;
    checar("b_parado", {3'b0, saida}, 8'h00);
    passo();
    chamada = 4'b0000;
    trecho("b_sobe0", 1'b1, 2'd0, 4'b0000);
    trecho("b_sobe1", 1'b1, 2'd1, 4'b0000);
    trecho("b_sobe2", 1'b1, 2'd2, 4'b0000);
    porta_ciclos("b_porta", 2'd3, 4);
    checar("b_pend", {4'b0, chamadas_pendentes}, 8'h00);
    $display("transaction: travel 0 -> 3");

    // Up with floor 0 also pending: finish the upward run, then reverse.
    reset = 1'b1;
    passo();
    reset = 1'b0;
    checar("c_rst", {3'b0, saida}, 8'h00);
    chamada = 4'b1000;
    passo();
    chamada = 4'b0000;
    trecho("c_sobe0", 1'b1, 2'd0, 4'b0001);
    checar("c_pend1001", {4'b0, chamadas_pendentes}, 8'h09);
    trecho("c_sobe1", 1'b1, 2'd1, 4'b0000);
    trecho("c_sobe2", 1'b1, 2'd2, 4'b0000);
    porta_ciclos("c_porta3", 2'd3, 4);
    checar("c_pend0001", {4'b0, chamadas_pendentes}, 8'h01);
    trecho("c_desce3", 1'b0, 2'd3, 4'b0000);
    trecho("c_desce2", 1'b0, 2'd2, 4'b0000);
    trecho("c_desce1", 1'b0, 2'd1, 4'b0000);
    porta_ciclos("c_porta0", 2'd0, 4);
    checar("c_pend_fim", {4'b0, chamadas_pendentes}, 8'h00);
    $display("transaction: serve 3 then reverse to 0");

    // Overload holds the door open; 4 more cycles after it clears.
    chamada = 4'b0001;
    passo();
    chamada = 4'b0000;
    checar("d_c1", {3'b0, saida}, 8'h01);
    passo();
    capacidade_atual = 2'b11;
    for (int i = 0; i < 20; i++) begin
      checar("d_excesso_porta", {3'b0, saida}, 8'h01);
      checar("d_excesso", {7'b0, excesso}, 8'h01);
      passo();
    end
    capacidade_atual = 2'b00;
    porta_ciclos("d_liberada", 2'd0, 4);
    $display("transaction: overload holds door");

    // Reset mid-travel between floors 1 and 2.
    chamada = 4'b0100;
    checar("e_parado", {3'b0, saida}, 8'h00);
    passo();
    chamada = 4'b0000;
    trecho("e_sobe0", 1'b1, 2'd0, 4'b0000);
    passo();
    passo();
    checar("e_viagem", {3'b0, saida}, 8'h0C);
    checar("e_pend", {4'b0, chamadas_pendentes}, 8'h04);
    reset = 1'b1;
    passo();
    checar("e_rst_saida", {3'b0, saida}, 8'h00);
    checar("e_rst_pend", {4'b0, chamadas_pendentes}, 8'h00);
    reset = 1'b0;
    passo();
    checar("e_pos_rst", {3'b0, saida}, 8'h00);
    checar("e_pos_rst_pend", {4'b0, chamadas_pendentes}, 8'h00);
    $display("transaction: reset mid-travel");

    $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
    $finish;
  end

endmodule

// File: doc/controle_elevador.md
CONTROLE_ELEVADOR -- requirements
Module: controle_elevador

Interface
REQ-001 Parameter CICLOS_ANDAR, default 8, clock cycles to travel one floor (legal range 2..255).
REQ-002 Parameter CICLOS_PORTA, default 4, clock cycles the door stays open without overload (legal range 1..255).
REQ-003 Port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port chamada  in  4  per-floor call buttons, bit i = floor i; each sampled every cycle; a one-cycle pulse is sufficient.
REQ-006 Port capacidade_atual  in  2  load level; 2'b11 = capacity exceeded.
REQ-007 Port andar_atual  out  2  current floor, 0..3.
REQ-008 Port motor_sobe  out  1  high while the car moves up.
REQ-009 Port motor_desce  out  1  high while the car moves down.
REQ-010 Port porta_aberta  out  1  high while the door is open.
REQ-011 Port chamadas_pendentes  out  4  registered pending-call vector.
REQ-012 Port excesso  out  1  combinational: capacidade_atual == 2'b11.

Function
REQ-013 The FSM SHALL have exactly four states: PARADO, SUBINDO, DESCENDO, PORTA_ABERTA.
REQ-014 Every cycle, pend SHALL be updated as pend <= pend | chamada; the clear rules in REQ-016 and REQ-020 take priority for the current-floor bit.
REQ-015 "Effective calls" SHALL mean pend | chamada, evaluated combinationally.
REQ-016 In PARADO, if effective[andar_atual] is set, the FSM SHALL go to PORTA_ABERTA on the next edge and clear that pend bit; porta_aberta is high from the cycle after the call is sampled.
REQ-017 In PARADO, with no current-floor call, the FSM SHALL go to SUBINDO if any effective call lies above and (dir_sobe = 1 or none lies below); otherwise it SHALL go to DESCENDO if any call lies below; otherwise it SHALL stay in PARADO. dir_sobe SHALL be updated to the chosen direction.
REQ-018 In SUBINDO or DESCENDO, the motor output SHALL be high for exactly CICLOS_ANDAR cycles. On the last cycle, andar_atual SHALL be updated by ±1 and the FSM SHALL go to PARADO, which re-evaluates the calls (one-cycle stop).
REQ-019 The FSM SHALL never request up motion at floor 3 or down motion at floor 0; no wrap-around is permitted.
REQ-020 In PORTA_ABERTA, the door timer SHALL load CICLOS_PORTA on entry and decrement each cycle. A new call for the current floor SHALL reload the timer and SHALL NOT set its pend bit.
REQ-021 PORTA_ABERTA SHALL exit to PARADO only when the timer has expired and excesso = 0. While excesso = 1 the door SHALL remain open indefinitely, and the timer SHALL reload when excesso falls.
REQ-022 motor_sobe, motor_desce and porta_aberta SHALL be mutually exclusive, and all SHALL be decoded from the state register.
REQ-023 Calls for floors other than the current one, arriving in any state, SHALL be retained until that floor's door opens.

Reset
REQ-024 On reset, outputs and state SHALL be: state = PARADO, andar_atual = 0, pend = 0, dir_sobe = 1, both timers = 0, all motor and door outputs = 0. excesso still follows its input.
REQ-025 Reset asserted mid-travel or with the door open SHALL abandon the operation and discard all pending calls.

Structure
REQ-026 Package pkg_elevador SHALL hold the state enum, NUM_ANDARES = 4, and the capacity-exceeded code 2'b11.
REQ-027 A single sub-module, temporizador_elevador (8-bit loadable down-counter with a done flag), SHALL serve both the travel timer and the door timer; they are never active at the same time.

Verification
REQ-028 After reset, pulse chamada = 4'b0001 -> porta_aberta is high for exactly 4 cycles starting the next cycle, then the FSM returns to PARADO, andar_atual = 0.
REQ-029 Pulse chamada = 4'b1000 -> motor_sobe high for 24 cycles with one-cycle PARADO gaps at floors 1 and 2; andar_atual = 3; door then opens for 4 cycles.
REQ-030 At floor 2, moving up, pend = 4'b1001 -> floor 3 is served first, then the car reverses to floor 0 (dir_sobe = 0).
REQ-031 Door open, capacidade_atual = 2'b11 held for 20 cycles -> porta_aberta stays high throughout; after release it stays open exactly 4 more cycles.
REQ-032 Assert reset mid-travel between floors 1 and 2 with pend = 4'b0100 -> next cycle: andar_atual = 0, pend = 0, all outputs low.
